pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM-subset pipeline.
- Drives the freeze and flush controls of the IF, ID, EX and MEM stage registers.
- Resolves three conditions:
  - RAW data hazards, by stalling IF and inserting a bubble into the ID stage register.
  - Taken branches, by flushing IF/ID.
  - Multi-cycle SRAM accesses, by freezing the whole pipe.
- Keeps a saturating stall counter and a sticky memory-timeout flag for debug.

Parameters:
- MEM_TIMEOUT, 64: wait cycles in MEM_WAIT before mem_timeout_err sets.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- id_src1  in  LEN_REG_ADDRESS  ID-stage source register 1
- id_src2  in  LEN_REG_ADDRESS  ID-stage source register 2
- id_src1_valid  in  1  instruction in ID reads src1
- id_src2_valid  in  1  instruction in ID reads src2
- ex_dest  in  LEN_REG_ADDRESS  destination register in EX
- ex_wb_en  in  1  EX instruction writes back
- ex_mem_read  in  1  EX instruction is a load
- mem_dest  in  LEN_REG_ADDRESS  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- branch_taken  in  1  taken branch resolved in EX
- mem_req  in  1  MEM stage access (read or write) active
- mem_ready  in  1  SRAM controller completes the access this cycle
- if_freeze  out  1  hold PC and IF stage register
- if_flush  out  1  clear IF stage register
- id_freeze  out  1  hold ID stage register
- id_flush  out  1  load bubble into ID stage register
- ex_freeze  out  1  hold EX stage register
- mem_freeze  out  1  hold MEM stage register
- stall_count  out  CNT_W  cycles with any freeze or bubble, saturating
- mem_timeout_err  out  1  sticky; wait exceeded MEM_TIMEOUT

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=RUN; wait_cnt=0; stall_count=0; mem_timeout_err=0.
  - While rst=0, combinational outputs are forced: if_flush=1, id_flush=1, all freezes 0.
- FSM states: RUN, MEM_WAIT. Control outputs are combinational from state and inputs (zero latency).
- mem_stall = (state==RUN & mem_req & ~mem_ready) | (state==MEM_WAIT & ~mem_ready).
- Transitions:
  - RUN -> MEM_WAIT when mem_req & ~mem_ready.
  - MEM_WAIT -> RUN when mem_ready.
  - mem_ready together with mem_req in RUN: no wait and no freeze.
- Priority, first match wins:
  1. mem_stall:
     - if_freeze = id_freeze = ex_freeze = mem_freeze = 1.
     - No flushes.
     - branch_taken and hazards are ignored (EX is held, so they are re-evaluated after release).
  2. branch_taken:
     - if_flush = id_flush = 1; all freezes 0.
     - Any hazard is suppressed because the instruction in ID is discarded.
  3. hazard:
     - if_freeze = 1, id_flush = 1 (bubble); id/ex/mem freezes 0.
  4. Otherwise all outputs 0.
- Source match: match(d) = (id_src1_valid & id_src1==d) | (id_src2_valid & id_src2==d).
- Hazard definition depends on FORWARDING_EN (see Optional Feature).
- wait_cnt:
  - Clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - When wait_cnt == MEM_TIMEOUT-1 and ~mem_ready, mem_timeout_err sets.
  - State stays MEM_WAIT; wait_cnt stops at MEM_TIMEOUT-1.
  - mem_timeout_err clears only on reset.
- stall_count: increments when any freeze or id_flush-from-hazard is active; saturates at all-ones. Branch flushes do not count.
- Reset mid-MEM_WAIT: state returns to RUN; mem_req from the reset pipe is expected to be 0.

Optional Feature:
- Macro: PIPELINE_FORWARDING_EN.
- Defined: hazard = ex_wb_en & ex_mem_read & match(ex_dest), i.e. load-use only. The EX forwarding unit covers all other RAW cases.
- Undefined: hazard = (ex_wb_en & match(ex_dest)) | (mem_wb_en & match(mem_dest)). There is no forwarding, so any pending write in EX or MEM stalls.

Decomposition:
- Shared package/ISA include:
  - LEN_REG_ADDRESS.
  - State encoding constants (ST_RUN=1'b0, ST_MEM_WAIT=1'b1).
- One sub-module, hazard_detect: purely combinational match/hazard logic, containing the macro-dependent code. The FSM, counters and priority mux stay in the top module.

Test Plan:
- Load-use (forwarding on): ex_mem_read=1, ex_wb_en=1, ex_dest=4'd3, id_src1=4'd3, id_src1_valid=1 -> if_freeze=1, id_flush=1, stall_count 0->1 next edge.
- Same stimulus with ex_mem_read=0: forwarding on -> no stall; forwarding off -> if_freeze=1, id_flush=1. Also mem_dest=3 with mem_wb_en=1 stalls only when forwarding is off.
- mem_req=1 with mem_ready low for 3 cycles, then high:
  - all four freezes stay 1 for exactly 3 cycles, 0 in the ready cycle;
  - state returns to RUN; stall_count=3.
- branch_taken=1 simultaneous with a load-use hazard -> if_flush=1, id_flush=1, if_freeze=0; stall_count unchanged. With mem_stall also active -> freezes only, no flush.
- MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> mem_timeout_err=1 after the 4th wait cycle; stays 1 after mem_ready; cleared only by rst=0.
- rst=0 during MEM_WAIT -> next edge: state RUN, counters 0, if_flush=id_flush=1 while rst=0, all freezes 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared register-address width, FSM encoding and source-match helper
package pipeline_hazard_ctrl_pkg;

    localparam int LEN_REG_ADDRESS = 4;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    function automatic logic reg_match(
        input logic [LEN_REG_ADDRESS-1:0] src1,
        input logic                       src1_valid,
        input logic [LEN_REG_ADDRESS-1:0] src2,
        input logic                       src2_valid,
        input logic [LEN_REG_ADDRESS-1:0] dest
    );
        return (src1_valid && (src1 == dest)) || (src2_valid && (src2 == dest));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational RAW hazard detection; PIPELINE_FORWARDING_EN selects load-use-only mode
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [LEN_REG_ADDRESS-1:0] id_src1,
    input  logic [LEN_REG_ADDRESS-1:0] id_src2,
    input  logic                       id_src1_valid,
    input  logic                       id_src2_valid,
    input  logic [LEN_REG_ADDRESS-1:0] ex_dest,
    input  logic                       ex_wb_en,
    input  logic                       ex_mem_read,
    input  logic [LEN_REG_ADDRESS-1:0] mem_dest,
    input  logic                       mem_wb_en,
    output logic                       hazard
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(id_src1, id_src1_valid, id_src2, id_src2_valid, ex_dest);
    assign mem_match = reg_match(id_src1, id_src1_valid, id_src2, id_src2_valid, mem_dest);

`ifdef PIPELINE_FORWARDING_EN
    // Forwarding covers every RAW case except a load whose data is not yet back.
    assign hazard = ex_wb_en & ex_mem_read & ex_match;

    logic unused_mem_side;
    assign unused_mem_side = mem_wb_en | mem_match;
`else
    assign hazard = (ex_wb_en & ex_match) | (mem_wb_en & mem_match);

    logic unused_load_flag;
    assign unused_load_flag = ex_mem_read;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush sequencer with SRAM wait FSM; hazard rule set by PIPELINE_FORWARDING_EN
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_REG_ADDRESS-1:0] id_src1,
    input  logic [LEN_REG_ADDRESS-1:0] id_src2,
    input  logic                       id_src1_valid,
    input  logic                       id_src2_valid,
    input  logic [LEN_REG_ADDRESS-1:0] ex_dest,
    input  logic                       ex_wb_en,
    input  logic                       ex_mem_read,
    input  logic [LEN_REG_ADDRESS-1:0] mem_dest,
    input  logic                       mem_wb_en,
    input  logic                       branch_taken,
    input  logic                       mem_req,
    input  logic                       mem_ready,
    output logic                       if_freeze,
    output logic                       if_flush,
    output logic                       id_freeze,
    output logic                       id_flush,
    output logic                       ex_freeze,
    output logic                       mem_freeze,
    output logic [CNT_W-1:0]           stall_count,
    output logic                       mem_timeout_err
);

    localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              hazard;
    logic              mem_stall;
    logic              hazard_bubble;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_src1_valid (id_src1_valid),
        .id_src2_valid (id_src2_valid),
        .ex_dest       (ex_dest),
        .ex_wb_en      (ex_wb_en),
        .ex_mem_read   (ex_mem_read),
        .mem_dest      (mem_dest),
        .mem_wb_en     (mem_wb_en),
        .hazard        (hazard)
    );

    assign mem_stall     = (state == ST_RUN) ? (mem_req & ~mem_ready) : ~mem_ready;
    assign hazard_bubble = ~mem_stall & ~branch_taken & hazard;

    always_comb begin
        if_freeze  = 1'b0;
        if_flush   = 1'b0;
        id_freeze  = 1'b0;
        id_flush   = 1'b0;
        ex_freeze  = 1'b0;
        mem_freeze = 1'b0;
        if (!rst) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (mem_stall) begin
            // Whole pipe held: branch and hazard are re-evaluated once EX moves again.
            if_freeze  = 1'b1;
            id_freeze  = 1'b1;
            ex_freeze  = 1'b1;
            mem_freeze = 1'b1;
        end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (hazard) begin
            if_freeze = 1'b1;
            id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_RUN;
            wait_cnt        <= '0;
            stall_count     <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if ((mem_stall || hazard_bubble) && (stall_count != '1))
                stall_count <= stall_count + 1'b1;

            case (state)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
